regfile_32x32: RTL and testbench
================================

# regfile_32x32

General-purpose register file for the single-cycle CPU datapath. It receives the 5-bit destination register number chosen by the write-destination selector (rt or rd), together with the write-back data, and commits the write on the clock edge. It serves two combinational read ports to the ALU/branch stage and a third read port for debug. Register 0 always reads as zero.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth is 2**ADDR_W = 32

Ports:
- clk  input  1  core clock; all state changes on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- we  input  1  write enable from the control unit (RegWrite)
- waddr  input  ADDR_W  destination register number from the write-destination selector
- wdata  input  DATA_W  write-back data (ALU result or memory load data)
- raddr1  input  ADDR_W  read port 1 index (rs)
- rdata1  output  DATA_W  read port 1 data
- raddr2  input  ADDR_W  read port 2 index (rt)
- rdata2  output  DATA_W  read port 2 data
- dbg_addr  input  ADDR_W  debug read index
- dbg_data  output  DATA_W  debug read data
- wr_count  output  16  number of committed writes since reset; saturates at 16'hFFFF

## Operation
- Storage: 32 entries of DATA_W bits. Entry 0 is not a storage element and reads as 0.
- Write: on the rising clk edge with we=1 and waddr!=0, entry[waddr] <= wdata. A write with waddr=0 is discarded and does not increment wr_count.
- Read: rdataN = entry[raddrN]. This is combinational and reflects state after the most recent edge (see Configuration). raddrN=0 returns 0.
- Debug read: dbg_data = entry[dbg_addr]. It is never bypassed and always shows committed state.
- wr_count increments by 1 on each committed write and holds at 16'hFFFF.
- Reset: while rst_n=0, all entries = 0 and wr_count = 0, independent of clk. After reset, rdata1, rdata2 and dbg_data read 0 for every address.
- Reset deasserted mid-cycle: the first write is taken on the first rising edge at which rst_n=1.
- A write that coincides with rst_n asserted is lost.
- X on waddr while we=1 is a protocol violation; the bench flags it as an error.

## Timing
- Write latency is 1 cycle. Data presented at edge N is visible on the read ports after edge N without bypass, and in the same cycle as the request with bypass.
- Read paths are purely combinational from raddr to rdata. There are no read-side registers.
- Reset is asynchronous on assertion. Deassertion must be synchronized upstream; this block does not synchronize it.
- Simultaneous events:
  - A read and a write to the same index in the same cycle return the old value without bypass and wdata with bypass.
  - The two read ports may use the same index. They return identical data.

## Configuration
- REGFILE_BYPASS_EN defined: rdataN = wdata when we=1, waddr!=0 and raddrN==waddr, giving write-through forwarding for both read ports.
- REGFILE_BYPASS_EN undefined: read ports return stored contents only.
- wr_count and dbg_data behave the same in both builds.

## Test plan
- Reset: hold rst_n=0 mid-cycle with stale data loaded -> all rdata1/rdata2/dbg_data = 0 for addresses 0..31; wr_count = 0.
- Write/read sweep: write 32'hA5A5_0000+i to reg i for i=1..31, then read all indices on both ports -> exact values returned; wr_count = 31.
- Zero register: we=1, waddr=0, wdata=32'hFFFF_FFFF -> rdata1 at raddr1=0 is 0 and wr_count is unchanged.
- Same-cycle read/write: reg 7 holds 32'h1111_1111; write 32'h2222_2222 to reg 7 with raddr1=7 -> 32'h1111_1111 in the same cycle without bypass or 32'h2222_2222 with REGFILE_BYPASS_EN; both builds read 32'h2222_2222 after the edge; dbg_data at 7 reads 32'h1111_1111 before the edge in both builds.
- we=0 with waddr=9 and wdata=32'hDEAD_BEEF -> reg 9 is unchanged and wr_count does not move.
- Saturation: force 65540 writes -> wr_count = 16'hFFFF and stays there.

Source files
------------

// File: rtl/regfile_if.sv
// Register file access bundle: one write port, two datapath read ports, one debug read port
// and the committed-write counter. The datapath drives through master; the register file is the slave.
interface regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // Handshake: there is no valid/ready pair. A write is requested by we=1 and is
    // committed on the next rising clk edge unless waddr is 0 or reset is asserted.
    // Reads have no request: rdataN and dbg_data follow their addresses combinationally.
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [15:0]       wr_count;

    modport master (
        output we, waddr, wdata, raddr1, raddr2, dbg_addr,
        input  rdata1, rdata2, dbg_data, wr_count
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, dbg_addr,
        output rdata1, rdata2, dbg_data, wr_count
    );
endinterface

// File: rtl/regfile_32x32.sv
// 32-entry general-purpose register file with two combinational read ports, a debug read port
// and a saturating write counter. Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_32x32 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    regfile_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Entry 0 is hardwired to zero, so storage starts at index 1.
    logic [DATA_W-1:0] mem [1:DEPTH-1];
    logic [15:0]       wr_cnt_q;
    logic              wr_commit;
    logic [DATA_W-1:0] rd1_stored;
    logic [DATA_W-1:0] rd2_stored;
    logic [DATA_W-1:0] dbg_stored;

    // A write held during reset is lost, so it must not commit or forward either.
    assign wr_commit = rst_n && bus.we && (bus.waddr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_commit) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
        end else if (wr_commit && (wr_cnt_q != CNT_MAX)) begin
            wr_cnt_q <= wr_cnt_q + 16'd1;
        end
    end

    always_comb begin
        rd1_stored = '0;
        if (bus.raddr1 != '0) begin
            rd1_stored = mem[bus.raddr1];
        end
    end

    always_comb begin
        rd2_stored = '0;
        if (bus.raddr2 != '0) begin
            rd2_stored = mem[bus.raddr2];
        end
    end

    // The debug port always shows committed contents, in both builds.
    always_comb begin
        dbg_stored = '0;
        if (bus.dbg_addr != '0) begin
            dbg_stored = mem[bus.dbg_addr];
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        bus.rdata1 = rd1_stored;
        if (wr_commit && (bus.raddr1 == bus.waddr)) begin
            bus.rdata1 = bus.wdata;
        end
    end

    always_comb begin
        bus.rdata2 = rd2_stored;
        if (wr_commit && (bus.raddr2 == bus.waddr)) begin
            bus.rdata2 = bus.wdata;
        end
    end
`else
    assign bus.rdata1 = rd1_stored;
    assign bus.rdata2 = rd2_stored;
`endif

    assign bus.dbg_data = dbg_stored;
    assign bus.wr_count = wr_cnt_q;
endmodule

// File: tb/tb_regfile_32x32.sv
// Randomized self-checking bench for regfile_32x32 against an array model of the register file.
// Expected same-cycle read values follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_32x32;
  logic clk;
  logic rst_n;

  regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_32x32 #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic [31:0] model [32];
  int unsigned model_cnt;
  logic [31:0] exp_q [$];

  function automatic logic [31:0] stored(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : model[a];
  endfunction

  function automatic logic [31:0] exp_port(input logic [4:0] a);
    logic [31:0] v;
    v = stored(a);
`ifdef REGFILE_BYPASS_EN
    if (rst_n === 1'b1 && bus.we === 1'b1 && bus.waddr != 5'd0 && bus.waddr == a) v = bus.wdata;
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    model_cnt = 0;
  endtask

  // Advance one rising edge and apply its effect to the model.
  task automatic tick();
    @(posedge clk);
    if (rst_n === 1'b1 && bus.we === 1'b1 && bus.waddr != 5'd0) begin
      model[bus.waddr] = bus.wdata;
      if (model_cnt < 32'hFFFF) model_cnt++;
    end
  endtask

  // X on waddr while writing is a protocol violation.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && bus.we === 1'b1 && $isunknown(bus.waddr)) begin
      n_err++;
      $display("FAIL x_waddr: waddr=%b with we=1, required a known index", bus.waddr);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.we = 1'b0;
    bus.waddr = '0;
    bus.wdata = '0;
    bus.raddr1 = '0;
    bus.raddr2 = '0;
    bus.dbg_addr = '0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.we = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    tick();
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 1; i < 32; i++) do_write(5'(i), $urandom);
    @(negedge clk);
    bus.we = 1'b1;
    bus.waddr = 5'd5;
    bus.wdata = 32'h0BAD_F00D;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    if (bus.wr_count !== 16'd0) begin
      n_err++; $display("FAIL reset_count: got %h want 0000", bus.wr_count);
    end
    n_vec++;
    for (int i = 0; i < 32; i++) begin
      bus.raddr1 = 5'(i); bus.raddr2 = 5'(31 - i); bus.dbg_addr = 5'(i);
      #1;
      if (bus.rdata1 !== 32'd0 || bus.rdata2 !== 32'd0 || bus.dbg_data !== 32'd0) begin
        n_err++;
        $display("FAIL reset_read[%0d]: got %h/%h/%h want 0", i, bus.rdata1, bus.rdata2, bus.dbg_data);
      end
      n_vec++;
    end
    // A write held across an edge in reset is lost.
    bus.raddr1 = 5'd5; bus.dbg_addr = 5'd5;
    tick();
    #1;
    if (bus.dbg_data !== 32'd0 || bus.rdata1 !== 32'd0 || bus.wr_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_write_lost: got dbg=%h rd1=%h cnt=%h want 0", bus.dbg_data, bus.rdata1, bus.wr_count);
    end
    n_vec++;
    // Deassert mid-cycle with the write still requested: the next edge takes it.
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    @(negedge clk);
    bus.we = 1'b0;
    #1;
    if (bus.dbg_data !== 32'h0BAD_F00D || bus.wr_count !== 16'd1 || model_cnt != 1) begin
      n_err++;
      $display("FAIL reset_first_write: got dbg=%h cnt=%h want 0bad_f00d/0001", bus.dbg_data, bus.wr_count);
    end
    n_vec++;
  endtask

  task automatic test_sweep();
    apply_reset();
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'hA5A5_0000 + 32'(i));
    for (int i = 0; i < 32; i++) begin
      bus.raddr1 = 5'(i); bus.raddr2 = 5'(i); bus.dbg_addr = 5'(i);
      #1;
      if (bus.rdata1 !== stored(5'(i)) || bus.rdata2 !== stored(5'(i)) || bus.dbg_data !== stored(5'(i))) begin
        n_err++;
        $display("FAIL sweep[%0d]: got %h/%h/%h want %h", i, bus.rdata1, bus.rdata2, bus.dbg_data, stored(5'(i)));
      end
      n_vec++;
    end
    if (bus.wr_count !== 16'd31) begin
      n_err++; $display("FAIL sweep_count: got %0d want 31", bus.wr_count);
    end
    n_vec++;
  endtask

  task automatic test_zero_reg();
    logic [15:0] cnt_before;
    cnt_before = bus.wr_count;
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFF_FFFF; bus.raddr1 = 5'd0;
    #1;
    if (bus.rdata1 !== 32'd0) begin
      n_err++; $display("FAIL zero_same_cycle: got %h want 0", bus.rdata1);
    end
    n_vec++;
    tick();
    @(negedge clk);
    bus.we = 1'b0;
    #1;
    if (bus.rdata1 !== 32'd0 || bus.wr_count !== 16'(model_cnt) || bus.wr_count !== cnt_before) begin
      n_err++; $display("FAIL zero_reg: got rd1=%h cnt=%0d want 0/%0d", bus.rdata1, bus.wr_count, model_cnt);
    end
    n_vec++;
  endtask

  task automatic test_same_cycle();
    logic [31:0] want_now;
    do_write(5'd7, 32'h1111_1111);
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h2222_2222;
    bus.raddr1 = 5'd7; bus.raddr2 = 5'd7; bus.dbg_addr = 5'd7;
`ifdef REGFILE_BYPASS_EN
    want_now = 32'h2222_2222;
`else
    want_now = 32'h1111_1111;
`endif
    #1;
    if (bus.rdata1 !== want_now || bus.rdata2 !== want_now) begin
      n_err++; $display("FAIL same_cycle_read: got %h/%h want %h", bus.rdata1, bus.rdata2, want_now);
    end
    n_vec++;
    if (bus.dbg_data !== 32'h1111_1111) begin
      n_err++; $display("FAIL same_cycle_dbg: got %h want 11111111", bus.dbg_data);
    end
    n_vec++;
    tick();
    @(negedge clk);
    bus.we = 1'b0;
    #1;
    if (bus.rdata1 !== 32'h2222_2222 || bus.dbg_data !== 32'h2222_2222) begin
      n_err++; $display("FAIL same_cycle_after: got %h/%h want 22222222", bus.rdata1, bus.dbg_data);
    end
    n_vec++;
  endtask

  task automatic test_we_low();
    @(negedge clk);
    bus.we = 1'b0; bus.waddr = 5'd9; bus.wdata = 32'hDEAD_BEEF; bus.dbg_addr = 5'd9; bus.raddr1 = 5'd9;
    tick();
    @(negedge clk);
    #1;
    if (bus.dbg_data !== stored(5'd9) || bus.rdata1 !== stored(5'd9) || bus.wr_count !== 16'(model_cnt)) begin
      n_err++;
      $display("FAIL we_low: got dbg=%h cnt=%0d want %h/%0d", bus.dbg_data, bus.wr_count, stored(5'd9), model_cnt);
    end
    n_vec++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      bus.we = ($urandom_range(0, 3) != 0);
      bus.waddr = 5'($urandom_range(0, 31));
      bus.wdata = $urandom;
      bus.raddr1 = ($urandom_range(0, 3) == 0) ? bus.waddr : 5'($urandom_range(0, 31));
      bus.raddr2 = ($urandom_range(0, 3) == 0) ? bus.raddr1 : 5'($urandom_range(0, 31));
      bus.dbg_addr = ($urandom_range(0, 1) == 0) ? bus.waddr : 5'($urandom_range(0, 31));
      #1;
      if (bus.rdata1 !== exp_port(bus.raddr1) || bus.rdata2 !== exp_port(bus.raddr2) ||
          bus.dbg_data !== stored(bus.dbg_addr) || bus.wr_count !== 16'(model_cnt)) begin
        n_err++;
        $display("FAIL random[%0d]: got %h/%h/%h cnt=%0d want %h/%h/%h cnt=%0d", k,
                 bus.rdata1, bus.rdata2, bus.dbg_data, bus.wr_count,
                 exp_port(bus.raddr1), exp_port(bus.raddr2), stored(bus.dbg_addr), model_cnt);
      end
      n_vec++;
      tick();
    end
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [31:0] want;
    exp_q.delete();
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      bus.we = (k < 20);
      bus.waddr = 5'(k + 1);
      d = $urandom;
      bus.wdata = d;
      bus.raddr1 = 5'(k);
      bus.raddr2 = 5'(k);
      #1;
      if (k > 0) begin
        want = exp_q.pop_front();
        if (bus.rdata2 !== want || bus.rdata1 !== want) begin
          n_err++; $display("FAIL back_to_back[%0d]: got %h/%h want %h", k, bus.rdata1, bus.rdata2, want);
        end
        n_vec++;
      end
      if (k < 20) exp_q.push_back(d);
      tick();
    end
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 65540; k++) begin
      @(negedge clk);
      bus.we = 1'b1;
      bus.waddr = 5'($urandom_range(1, 31));
      bus.wdata = $urandom;
      if (model_cnt >= 32'hFFFC) begin
        #1;
        if (bus.wr_count !== 16'(model_cnt)) begin
          n_err++; $display("FAIL saturation[%0d]: got %h want %h", k, bus.wr_count, 16'(model_cnt));
        end
        n_vec++;
      end
      tick();
    end
    @(negedge clk);
    bus.we = 1'b0;
    #1;
    if (bus.wr_count !== 16'hFFFF) begin
      n_err++; $display("FAIL saturation_final: got %h want ffff", bus.wr_count);
    end
    n_vec++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    drive_idle();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    test_reset();
    test_sweep();
    test_zero_reg();
    test_same_cycle();
    test_we_low();
    test_random();
    test_back_to_back();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
